// File: rtl/arbitro_barramento3.sv
// Round-robin arbiter for a 3-requester shared 32-bit bus.
// Drives the registered one-hot grant, the bus mux select and the busy flag.
//
// Ports:
//   clock   : single clock, rising edge
//   reset   : synchronous, active-high
//   req     : level request per requester (bit i = requester i)
//   grant   : registered one-hot grant, 000 when idle
//   ctrl    : registered mux select, 0..2 = owner, 3 = idle (bus drives zero)
//   ocupado : registered busy flag, OR of grant
module arbitro_barramento3 #(
  parameter int QUANTUM = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] ctrl,
  output logic       ocupado
);

  typedef enum logic {
    OCIOSO,
    CONCEDIDO
  } estado_t;

  localparam logic [7:0] QMAX = 8'(QUANTUM);

  estado_t    estado, estado_n;
  logic [1:0] dono, dono_n;
  logic [1:0] ultimo, ultimo_n;
  logic [7:0] cont, cont_n;
  logic [2:0] grant_n;
  logic [1:0] ctrl_n;
  logic       ocupado_n;

  logic [1:0] base;
  logic [1:0] escolha;
  logic       dono_pede;
  logic       outros;

  // Scan starts just after the last winner; the last winner is tried last.
  function automatic logic [1:0] pick(
    input logic [1:0] u,
    input logic [2:0] r
  );
    logic [1:0] p;
    p = u;
    unique case (u)
      2'd0: begin
        if (r[1])      p = 2'd1;
        else if (r[2]) p = 2'd2;
        else           p = 2'd0;
      end
      2'd1: begin
        if (r[2])      p = 2'd2;
        else if (r[0]) p = 2'd0;
        else           p = 2'd1;
      end
      default: begin
        if (r[0])      p = 2'd0;
        else if (r[1]) p = 2'd1;
        else           p = 2'd2;
      end
    endcase
    return p;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] p);
    logic [2:0] g;
    g = 3'b000;
    unique case (p)
      2'd0:    g = 3'b001;
      2'd1:    g = 3'b010;
      2'd2:    g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  // In CONCEDIDO the grant register is onehot(dono), so it doubles as
  // the owner mask.
  assign dono_pede = |(req & grant);
  assign outros    = |(req & ~grant);
  assign base      = (estado == CONCEDIDO) ? dono : ultimo;
  assign escolha   = pick(base, req);

  always_comb begin
    estado_n  = estado;
    dono_n    = dono;
    ultimo_n  = ultimo;
    cont_n    = cont;
    grant_n   = grant;
    ctrl_n    = ctrl;
    ocupado_n = ocupado;

    unique case (estado)
      OCIOSO: begin
        if (|req) begin
          estado_n  = CONCEDIDO;
          dono_n    = escolha;
          ultimo_n  = escolha;
          grant_n   = onehot(escolha);
          ctrl_n    = escolha;
          ocupado_n = 1'b1;
          cont_n    = 8'd1;
        end
      end
      default: begin
        if ((!dono_pede && outros) ||
            (dono_pede && cont == QMAX && outros)) begin
          // Direct handover: no idle cycle between owners.
          dono_n    = escolha;
          ultimo_n  = escolha;
          grant_n   = onehot(escolha);
          ctrl_n    = escolha;
          ocupado_n = 1'b1;
          cont_n    = 8'd1;
        end else if (!dono_pede) begin
          estado_n  = OCIOSO;
          dono_n    = 2'd3;
          grant_n   = 3'b000;
          ctrl_n    = 2'd3;
          ocupado_n = 1'b0;
          cont_n    = 8'd0;
        end else if (cont < QMAX) begin
          cont_n = cont + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      dono    <= 2'd3;
      ultimo  <= 2'd2;
      cont    <= 8'd0;
      grant   <= 3'b000;
      ctrl    <= 2'd3;
      ocupado <= 1'b0;
    end else begin
      estado  <= estado_n;
      dono    <= dono_n;
      ultimo  <= ultimo_n;
      cont    <= cont_n;
      grant   <= grant_n;
      ctrl    <= ctrl_n;
      ocupado <= ocupado_n;
    end
  end

endmodule

// File: tb/tb_arbitro_barramento3.sv
// Directed bench for arbitro_barramento3 (QUANTUM=4).
// Expected select codes are queued per step and checked after each edge.
module tb_arbitro_barramento3;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] ctrl;
  logic       ocupado;

  int errors = 0;
  int checks = 0;

  logic [1:0] expq[$];

  arbitro_barramento3 #(.QUANTUM(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .ctrl    (ctrl),
    .ocupado (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Apply inputs, queue the expected select, clock once, then compare.
  task automatic step(input string tag, input logic r,
                      input logic [2:0] q, input logic [1:0] e);
    logic [1:0] x;
    logic [2:0] g;
    reset = r;
    req   = q;
    expq.push_back(e);
    @(posedge clock);
    #1;
    x = expq.pop_front();
    g = (x == 2'd3) ? 3'b000 : (3'b001 << x);
    chk({tag, ".ctrl"}, 8'(ctrl), 8'(x));
    chk({tag, ".grant"}, 8'(grant), 8'(g));
    chk({tag, ".ocupado"}, 8'(ocupado), 8'(x != 2'd3));
    chk({tag, ".onehot"}, 8'($countones(grant) <= 1), 8'd1);
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b111;

    step("rst0", 1, 3'b111, 2'd3);
    step("rst1", 1, 3'b111, 2'd3);

    // Full contention: 0x4, 1x4, 2x4, 0x4 ...
    for (int i = 0; i < 4; i++) step("cont0", 0, 3'b111, 2'd0);
    for (int i = 0; i < 4; i++) step("cont1", 0, 3'b111, 2'd1);
    for (int i = 0; i < 4; i++) step("cont2", 0, 3'b111, 2'd2);
    for (int i = 0; i < 4; i++) step("cont0b", 0, 3'b111, 2'd0);
    step("cont1b", 0, 3'b111, 2'd1);
    step("cont1b", 0, 3'b111, 2'd1);

    // Reset mid-grant: owner 1 at this point, then reach owner 2.
    step("pre2", 0, 3'b111, 2'd1);
    step("pre2", 0, 3'b111, 2'd1);
    step("pre2", 0, 3'b111, 2'd2);
    step("midrst", 1, 3'b111, 2'd3);
    step("postrst", 0, 3'b111, 2'd0);
    step("clean", 1, 3'b000, 2'd3);

    // Single requester holds past the quantum, then releases.
    for (int i = 0; i < 6; i++) step("single", 0, 3'b010, 2'd1);
    step("release", 0, 3'b000, 2'd3);

    // Early release with direct handover to requester 2.
    step("early", 0, 3'b001, 2'd0);
    step("early", 0, 3'b001, 2'd0);
    step("handover", 0, 3'b100, 2'd2);
    step("fullq", 0, 3'b111, 2'd2);
    step("fullq", 0, 3'b111, 2'd2);
    step("fullq", 0, 3'b111, 2'd2);
    step("fullq_pre", 0, 3'b111, 2'd0);
    step("idle", 0, 3'b000, 2'd3);

    // Late contender after the owner's counter saturated.
    for (int i = 0; i < 10; i++) step("late", 0, 3'b001, 2'd0);
    step("late_sw", 0, 3'b011, 2'd1);
    step("late_end", 0, 3'b000, 2'd3);

    chk("queue_empty", 8'(expq.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arbitro_barramento3.md
# arbitro_barramento3

Round-robin arbiter that shares one 32-bit bus between three requesters. It produces the 2-bit select for the 3-input bus mux: code 0/1/2 selects that requester, and code 3 makes the mux drive zero. A per-grant quantum counter stops one requester from holding the bus while others wait. It sits between the requester ports and the shared bus mux, and its select drives the mux's `ctrl` directly.

## Interface
- `QUANTUM`, default 4: maximum consecutive grant cycles while another requester is pending. Legal range 2..255.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `req`  in  3  per-requester level request; bit i belongs to requester i.
- `grant`  out  3  one-hot grant, registered; all zeros when no owner.
- `ctrl`  out  2  bus mux select, registered: 0/1/2 selects the owner, 3 means idle.
- `ocupado`  out  1  bus busy flag, registered; equals OR of `grant`.

## Operation
- State registers:
  - `estado` ∈ {OCIOSO, CONCEDIDO}.
  - `dono` (2 bits): current owner.
  - `ultimo` (2 bits): last requester granted.
  - `cont` (8 bits): saturating count of grant cycles.
- Reset values: estado=OCIOSO, grant=000, ctrl=3, ocupado=0, dono=3, ultimo=2, cont=0. Because ultimo=2, requester 0 wins the first arbitration.
- Round-robin pick: scan (ultimo+1) mod 3, then (ultimo+2) mod 3, then ultimo. The first requester found with req set wins. Only the values 0..2 occur in ultimo after reset.
- OCIOSO:
  - If req==000, stay; outputs keep their idle values.
  - Otherwise go to CONCEDIDO with dono=pick, ultimo=pick, grant=onehot(pick), ctrl=pick, cont=1.
- CONCEDIDO, evaluated at each edge with the current owner d:
  - **Release:** req[d]==0. If another req bit is set, hand over directly to the pick computed with ultimo=d: new owner, cont=1, no idle cycle. Otherwise go to OCIOSO with idle outputs.
  - **Preempt:** req[d]==1, cont==QUANTUM, and another req bit set. Hand over directly to the pick computed with ultimo=d; cont=1.
  - **Hold:** any other case. Owner keeps the grant; cont increments, saturating at QUANTUM.
- If the quantum has expired and no one else is requesting, the owner keeps the grant indefinitely with cont held at QUANTUM. Preemption happens on the first edge where another request appears.
- A requester that loses its grant while still requesting competes again through the round-robin order.
- Invariants, which the bench checks every cycle:
  - grant is one-hot or zero.
  - ctrl==3 exactly when grant==000.
  - ctrl==i exactly when grant[i]==1.
  - ocupado==|grant.

## Timing
- All outputs are registered, with no combinational path from req to any output.
- Grant latency from idle: req set before edge E gives grant and ctrl valid right after E, i.e. one cycle.
- Handover: at a single edge the old grant bit falls and the new one rises. Zero dead cycles; ctrl steps straight from the old code to the new one.
- Release latency: req[d] sampled low at edge E removes the grant at E.
- A contended owner sees exactly QUANTUM cycles of grant before preemption.
- Reset has priority over every transition. Asserted mid-grant, it forces the reset values at that edge regardless of req.
- Simultaneous events at one edge:
  - Owner release and new requests: handover to the pick; it never passes through OCIOSO.
  - Quantum expiry and owner drop: treated as a release.

## Test plan
- **Reset:** hold reset 2 cycles with req=111 → grant=000, ctrl=3, ocupado=0. First edge after reset release: grant=001, ctrl=0.
- **Single requester:** req=010 for 6 cycles, then 000 (QUANTUM=4) → grant=010 and ctrl=1 from one edge after req for 6 cycles (no preemption); then grant=000, ctrl=3 at the edge that samples req=000.
- **Full contention:** req=111 held, QUANTUM=4 → ctrl sequence 0×4, 1×4, 2×4, 0×4…; grant one-hot every cycle with no idle cycle between owners.
- **Early release with handover:** owner 0 drops req after 2 cycles while req[2]=1 and req[1]=0 → ctrl goes 0,0,2 at that edge; cont restarts so owner 2 gets a full quantum.
- **Late contender:** req=001 held for 10 cycles, req[1] rises at cycle 10 → grant stays 001 until req[1] is sampled; at that edge it switches to 010 (cont was saturated).
- **Reset mid-grant:** ctrl=2 with req=111, assert reset for 1 cycle → idle outputs at that edge. After release, the first grant goes to requester 0 (ultimo reset to 2).
